// File: rtl/mc_ctrl_pkg.sv
// +--------------------------------------------------------------------------+
// | mips_ctrl_pkg : opcodes, states and control-field codes for mc_ctrl (r1) |
// +--------------------------------------------------------------------------+
`default_nettype none

package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH = 4'd0,  S_DCD   = 4'd1,  S_EXE_R = 4'd2,  S_EXE_I = 4'd3,
    S_MA    = 4'd4,  S_MR    = 4'd5,  S_MW    = 4'd6,  S_WB_R  = 4'd7,
    S_WB_I  = 4'd8,  S_WB_LW = 4'd9,  S_BR    = 4'd10, S_JMP   = 4'd11
  } state_t;

  localparam logic [1:0] NPC_PLUS4 = 2'b00;
  localparam logic [1:0] NPC_BEQ   = 2'b01;
  localparam logic [1:0] NPC_JUMP  = 2'b10;
  localparam logic [1:0] NPC_JR    = 2'b11;

  localparam logic [1:0] WA_RT = 2'b00;
  localparam logic [1:0] WA_RD = 2'b01;
  localparam logic [1:0] WA_RA = 2'b10;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC4 = 2'b10;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;

  typedef struct packed {
    logic rtype_add;
    logic rtype_sub;
    logic jr;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic illegal;
  } insn_cls_t;

endpackage

`default_nettype wire

// File: rtl/mc_ctrl_if.sv
// +--------------------------------------------------------------------------+
// | mc_ctrl_if : IR fields, datapath flags and control outputs (r1)          |
// +--------------------------------------------------------------------------+
`default_nettype none

interface mc_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       dm_rdy;
  logic       pc_we;
  logic [1:0] npc_sel;
  logic       ir_we;
  logic       rf_we;
  logic [1:0] rf_wa_sel;
  logic [1:0] rf_wd_sel;
  logic [1:0] ext_op;
  logic       alu_src;
  logic [1:0] alu_op;
  logic       dm_re;
  logic       dm_we;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  op, funct, zero, dm_rdy,
    output pc_we, npc_sel, ir_we, rf_we, rf_wa_sel, rf_wd_sel,
           ext_op, alu_src, alu_op, dm_re, dm_we, illegal, state
  );

  modport slave (
    output op, funct, zero, dm_rdy,
    input  pc_we, npc_sel, ir_we, rf_we, rf_wa_sel, rf_wd_sel,
           ext_op, alu_src, alu_op, dm_re, dm_we, illegal, state
  );
endinterface

`default_nettype wire

// File: rtl/mc_ctrl_decode.sv
// +--------------------------------------------------------------------------+
// | mc_decode : op/funct to one-hot instruction class (r1)                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module mc_decode
  import mips_ctrl_pkg::*;
(
  input  wire logic [5:0] op,
  input  wire logic [5:0] funct,
  output insn_cls_t       cls
);

  always_comb begin
    cls = '0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: cls.rtype_add = 1'b1;
          FN_SUBU: cls.rtype_sub = 1'b1;
          FN_JR:   cls.jr        = 1'b1;
          default: cls.illegal   = 1'b1;
        endcase
      end
      OP_ORI:  cls.ori     = 1'b1;
      OP_LUI:  cls.lui     = 1'b1;
      OP_LW:   cls.lw      = 1'b1;
      OP_SW:   cls.sw      = 1'b1;
      OP_BEQ:  cls.beq     = 1'b1;
      OP_J:    cls.j       = 1'b1;
      OP_JAL:  cls.jal     = 1'b1;
      default: cls.illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mc_ctrl.sv
// +--------------------------------------------------------------------------+
// | mc_ctrl : multi-cycle MIPS control FSM, one PC write per instruction (r1)|
// +--------------------------------------------------------------------------+
`default_nettype none

module mc_ctrl
  import mips_ctrl_pkg::*;
(
  input  wire logic   clk,
  input  wire logic   rst,
  mc_ctrl_if.master   bus
);

  state_t    cur_state;
  state_t    nxt_state;
  insn_cls_t cls;

  logic       pc_we, ir_we, rf_we, alu_src, dm_re, dm_we, illegal;
  logic [1:0] npc_sel, rf_wa_sel, rf_wd_sel, ext_op, alu_op;

  // Branch outcome is resolved in the next-PC unit, not here.
  wire unused_zero = bus.zero;

  mc_decode u_decode (
    .op    (bus.op),
    .funct (bus.funct),
    .cls   (cls)
  );

  always_ff @(posedge clk) begin
    if (rst) cur_state <= S_FETCH;
    else     cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = S_FETCH;
    case (cur_state)
      S_FETCH: nxt_state = S_DCD;
      S_DCD: begin
        if (cls.rtype_add || cls.rtype_sub)  nxt_state = S_EXE_R;
        else if (cls.ori || cls.lui)         nxt_state = S_EXE_I;
        else if (cls.lw || cls.sw)           nxt_state = S_MA;
        else if (cls.beq)                    nxt_state = S_BR;
        else if (cls.j || cls.jal || cls.jr) nxt_state = S_JMP;
        else                                 nxt_state = S_FETCH;
      end
      S_EXE_R: nxt_state = S_WB_R;
      S_EXE_I: nxt_state = S_WB_I;
      S_MA:    nxt_state = cls.lw ? S_MR : S_MW;
      S_MR:    nxt_state = bus.dm_rdy ? S_WB_LW : S_MR;
      S_MW:    nxt_state = bus.dm_rdy ? S_FETCH : S_MW;
      default: nxt_state = S_FETCH;
    endcase
  end

  always_comb begin
    pc_we = 1'b0;  ir_we = 1'b0;  rf_we = 1'b0;  alu_src = 1'b0;
    dm_re = 1'b0;  dm_we = 1'b0;  illegal = 1'b0;
    npc_sel = NPC_PLUS4;  rf_wa_sel = WA_RT;  rf_wd_sel = WD_ALU;
    ext_op = EXT_ZERO;    alu_op = ALU_ADD;
    case (cur_state)
      S_FETCH: ir_we = 1'b1;
      S_DCD: begin
        illegal = cls.illegal;
        pc_we   = cls.illegal;
      end
      S_EXE_R: alu_op = cls.rtype_sub ? ALU_SUB : ALU_ADD;
      S_WB_R: begin
        rf_we = 1'b1;  rf_wa_sel = WA_RD;  pc_we = 1'b1;
      end
      S_EXE_I, S_WB_I: begin
        alu_src = 1'b1;
        alu_op  = ALU_OR;
        ext_op  = cls.lui ? EXT_LUI : EXT_ZERO;
        if (cur_state == S_WB_I) begin
          rf_we = 1'b1;  pc_we = 1'b1;
        end
      end
      S_MA: begin
        ext_op = EXT_SIGN;  alu_src = 1'b1;
      end
      S_MR: dm_re = 1'b1;
      S_WB_LW: begin
        rf_we = 1'b1;  rf_wd_sel = WD_MEM;  pc_we = 1'b1;
      end
      S_MW: begin
        dm_we = 1'b1;
        pc_we = bus.dm_rdy;
      end
      S_BR: begin
        alu_op = ALU_SUB;  ext_op = EXT_SIGN;  pc_we = 1'b1;  npc_sel = NPC_BEQ;
      end
      S_JMP: begin
        pc_we   = 1'b1;
        npc_sel = cls.jr ? NPC_JR : NPC_JUMP;
        if (cls.jal) begin
          rf_we = 1'b1;  rf_wa_sel = WA_RA;  rf_wd_sel = WD_PC4;
        end
      end
      default: ;
    endcase
    // Reset abandons the instruction: no writes or requests in that cycle.
    if (rst) begin
      pc_we = 1'b0;  ir_we = 1'b0;  rf_we = 1'b0;
      dm_re = 1'b0;  dm_we = 1'b0;  illegal = 1'b0;
    end
  end

  assign bus.pc_we     = pc_we;
  assign bus.npc_sel   = npc_sel;
  assign bus.ir_we     = ir_we;
  assign bus.rf_we     = rf_we;
  assign bus.rf_wa_sel = rf_wa_sel;
  assign bus.rf_wd_sel = rf_wd_sel;
  assign bus.ext_op    = ext_op;
  assign bus.alu_src   = alu_src;
  assign bus.alu_op    = alu_op;
  assign bus.dm_re     = dm_re;
  assign bus.dm_we     = dm_we;
  assign bus.illegal   = illegal;
  assign bus.state     = cur_state;

endmodule

`default_nettype wire

// File: tb/tb_mc_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_mc_ctrl : directed per-cycle state/control checks for mc_ctrl (r1)    |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_mc_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  mc_ctrl_if bus ();

  mc_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // {pc_we, npc_sel, ir_we, rf_we, rf_wa_sel, rf_wd_sel, ext_op, alu_src, alu_op, dm_re, dm_we, illegal}
  wire [16:0] ctlw = {bus.pc_we, bus.npc_sel, bus.ir_we, bus.rf_we, bus.rf_wa_sel,
                      bus.rf_wd_sel, bus.ext_op, bus.alu_src, bus.alu_op,
                      bus.dm_re, bus.dm_we, bus.illegal};

  function automatic logic [16:0] mk(logic pcwe, logic [1:0] npc, logic irwe, logic rfwe,
                                     logic [1:0] wa, logic [1:0] wd, logic [1:0] ext,
                                     logic src, logic [1:0] aop, logic re, logic we, logic ill);
    return {pcwe, npc, irwe, rfwe, wa, wd, ext, src, aop, re, we, ill};
  endfunction

  localparam logic [16:0] C_ZERO  = 17'd0;
  localparam logic [16:0] C_FETCH = 17'b0_00_1_0_00_00_00_0_00_0_0_0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Check the current cycle at negedge, then advance to just past the next edge.
  task automatic cyc(input string tag, input logic [3:0] st, input logic [16:0] c);
    @(negedge clk);
    check({tag, "_state"}, 32'(bus.state), 32'(st));
    check({tag, "_ctl"},   32'(ctlw),      32'(c));
    @(posedge clk);
    #1;
  endtask

  task automatic set_insn(input logic [5:0] op, input logic [5:0] fn);
    bus.op = op;
    bus.funct = fn;
  endtask

  initial begin
    bus.op = 6'd0;  bus.funct = 6'd0;  bus.zero = 1'b0;  bus.dm_rdy = 1'b1;
    @(posedge clk); #1;
    // Reset held: state FETCH, but ir_we is forced low.
    cyc("reset", 4'd0, C_ZERO);
    rst = 1'b0;

    // addu
    set_insn(6'b000000, 6'b100001);
    cyc("addu_f", 4'd0, C_FETCH);
    cyc("addu_d", 4'd1, C_ZERO);
    cyc("addu_e", 4'd2, C_ZERO);
    cyc("addu_w", 4'd7, mk(1, 2'b00, 0, 1, 2'b01, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0));

    // subu
    set_insn(6'b000000, 6'b100011);
    cyc("subu_f", 4'd0, C_FETCH);
    cyc("subu_d", 4'd1, C_ZERO);
    cyc("subu_e", 4'd2, mk(0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b01, 0, 0, 0));
    cyc("subu_w", 4'd7, mk(1, 2'b00, 0, 1, 2'b01, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0));

    // ori
    set_insn(6'b001101, 6'b000000);
    cyc("ori_f", 4'd0, C_FETCH);
    cyc("ori_d", 4'd1, C_ZERO);
    cyc("ori_e", 4'd3, mk(0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b10, 0, 0, 0));
    cyc("ori_w", 4'd8, mk(1, 2'b00, 0, 1, 2'b00, 2'b00, 2'b00, 1, 2'b10, 0, 0, 0));

    // lui
    set_insn(6'b001111, 6'b000000);
    cyc("lui_f", 4'd0, C_FETCH);
    cyc("lui_d", 4'd1, C_ZERO);
    cyc("lui_e", 4'd3, mk(0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b10, 1, 2'b10, 0, 0, 0));
    cyc("lui_w", 4'd8, mk(1, 2'b00, 0, 1, 2'b00, 2'b00, 2'b10, 1, 2'b10, 0, 0, 0));

    // lw with dm_rdy low for 3 MR cycles (also low, and ignored, before MR)
    set_insn(6'b100011, 6'b000000);
    bus.dm_rdy = 1'b0;
    cyc("lw_f", 4'd0, C_FETCH);
    cyc("lw_d", 4'd1, C_ZERO);
    cyc("lw_ma", 4'd4, mk(0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b01, 1, 2'b00, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      cyc("lw_mr_wait", 4'd5, mk(0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 1, 0, 0));
    bus.dm_rdy = 1'b1;
    cyc("lw_mr_rdy", 4'd5, mk(0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 1, 0, 0));
    cyc("lw_wb", 4'd9, mk(1, 2'b00, 0, 1, 2'b00, 2'b01, 2'b00, 0, 2'b00, 0, 0, 0));

    // sw, dm_rdy high
    set_insn(6'b101011, 6'b000000);
    cyc("sw_f", 4'd0, C_FETCH);
    cyc("sw_d", 4'd1, C_ZERO);
    cyc("sw_ma", 4'd4, mk(0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b01, 1, 2'b00, 0, 0, 0));
    cyc("sw_mw", 4'd6, mk(1, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 1, 0));

    // beq with zero = 0 then zero = 1: identical controls
    set_insn(6'b000100, 6'b000000);
    for (int z = 0; z < 2; z++) begin
      bus.zero = z[0];
      cyc("beq_f", 4'd0, C_FETCH);
      cyc("beq_d", 4'd1, C_ZERO);
      cyc("beq_br", 4'd10, mk(1, 2'b01, 0, 0, 2'b00, 2'b00, 2'b01, 0, 2'b01, 0, 0, 0));
    end

    // j, jal, jr
    set_insn(6'b000010, 6'b000000);
    cyc("j_f", 4'd0, C_FETCH);
    cyc("j_d", 4'd1, C_ZERO);
    cyc("j_jmp", 4'd11, mk(1, 2'b10, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0));
    set_insn(6'b000011, 6'b000000);
    cyc("jal_f", 4'd0, C_FETCH);
    cyc("jal_d", 4'd1, C_ZERO);
    cyc("jal_jmp", 4'd11, mk(1, 2'b10, 0, 1, 2'b10, 2'b10, 2'b00, 0, 2'b00, 0, 0, 0));
    set_insn(6'b000000, 6'b001000);
    cyc("jr_f", 4'd0, C_FETCH);
    cyc("jr_d", 4'd1, C_ZERO);
    cyc("jr_jmp", 4'd11, mk(1, 2'b11, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0));

    // Unsupported opcode, then unsupported R-type funct
    set_insn(6'b111111, 6'b000000);
    cyc("ill_op_f", 4'd0, C_FETCH);
    cyc("ill_op_d", 4'd1, mk(1, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 0, 1));
    set_insn(6'b000000, 6'b100000);
    cyc("ill_fn_f", 4'd0, C_FETCH);
    cyc("ill_fn_d", 4'd1, mk(1, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 0, 1));

    // sw stalled in MW, then reset mid-wait
    set_insn(6'b101011, 6'b000000);
    bus.dm_rdy = 1'b0;
    cyc("swr_f", 4'd0, C_FETCH);
    cyc("swr_d", 4'd1, C_ZERO);
    cyc("swr_ma", 4'd4, mk(0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b01, 1, 2'b00, 0, 0, 0));
    cyc("swr_mw", 4'd6, mk(0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 1, 0));
    rst = 1'b1;
    cyc("swr_rst", 4'd6, C_ZERO);
    rst = 1'b0;
    bus.dm_rdy = 1'b1;
    set_insn(6'b000000, 6'b100001);
    cyc("post_f", 4'd0, C_FETCH);
    cyc("post_d", 4'd1, C_ZERO);
    cyc("post_e", 4'd2, C_ZERO);
    cyc("post_w", 4'd7, mk(1, 2'b00, 0, 1, 2'b01, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0));
    cyc("post_f2", 4'd0, C_FETCH);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
